// File: rtl/rvm_lsu.sv
// rvm_lsu: load/store unit between the core control FSM and the data memory.
//
// Accepts one load or store at a time. The access is presented as a
// word-aligned memory cycle with byte lanes. The unit holds that cycle across
// memory stalls, then extracts and extends the load data. It finishes with a
// one-cycle response pulse that carries an error flag.
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready.
// req_ready is high only in IDLE. The response has no backpressure: rsp_valid
// is high for exactly one cycle, and the consumer must take it then.
// mem_stall applies only while mem_c_en is high. mem_rdata/mem_error are
// sampled in the cycle after the unstalled access cycle.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req_*           request (valid/ready, store, size, signed, addr, wdata)
//   rsp_*           registered response (valid pulse, rdata, error)
//   mem_*           memory port (addr, wdata, c_en, b_en out; rdata, error,
//                   stall in)
//   fsm_state       current FSM state (0 IDLE, 1 ACCESS, 2 CAPTURE, 3 RESP)
//
// Build option: define RVM_LSU_MISALIGN_TRAP_EN to reject misaligned half and
// word requests with an error and no memory access. Without it, the access
// is made to the aligned half or word that contains the address.
module rvm_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic        mem_c_en,
    output logic [3:0]  mem_b_en,
    input  logic        mem_error,
    input  logic        mem_stall,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state;
    logic        r_store;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        bad_req;
    logic [1:0]  lane_off;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Requests that never reach memory: illegal size, plus misaligned
    // half/word accesses when trapping is built in.
    always_comb begin
        bad_req = (req_size == 2'b11);
`ifdef RVM_LSU_MISALIGN_TRAP_EN
        if (req_size == 2'b01 && req_addr[0])
            bad_req = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
`endif
    end

    // Lane selection from the registered request. Half and word accesses
    // drop the low address bits, so an unchecked misaligned access lands on
    // the aligned unit that contains the address.
    always_comb begin
        lane_off  = 2'b00;
        lane_en   = 4'b1111;
        lane_data = r_wdata;
        case (r_size)
            2'b00: begin
                lane_off  = r_addr[1:0];
                lane_en   = 4'b0001 << r_addr[1:0];
                lane_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                lane_off  = {r_addr[1], 1'b0};
                lane_en   = r_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{r_wdata[15:0]}};
            end
            default: begin
                lane_off  = 2'b00;
                lane_en   = 4'b1111;
                lane_data = r_wdata;
            end
        endcase
    end

    // Load extraction, used only in CAPTURE.
    always_comb begin
        shifted  = mem_rdata >> {lane_off, 3'b000};
        load_val = shifted;
        case (r_size)
            2'b00: load_val = r_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'd0, shifted[7:0]};
            2'b01: load_val = r_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // The memory port decodes only from state and registered request. An
    // async reset of state therefore drops mem_c_en immediately.
    assign mem_c_en  = (state == ACCESS);
    assign mem_addr  = mem_c_en ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_b_en  = mem_c_en ? lane_en : 4'd0;
    assign mem_wdata = (mem_c_en && r_store) ? lane_data : 32'd0;
    assign req_ready = (state == IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            r_store   <= 1'b0;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (bad_req) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!mem_stall)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_error <= mem_error;
                    rsp_rdata <= (mem_error || r_store) ? 32'd0 : load_val;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_lsu.sv
// Bench for rvm_lsu: directed cases plus randomized loads/stores checked
// against an arithmetic reference model and an expected-response queue.
module tb_rvm_lsu;

`ifdef RVM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;
    int rsp_expected = 0;
    logic [32:0] exp_q[$];

    rvm_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_c_en(mem_c_en), .mem_b_en(mem_b_en), .mem_error(mem_error),
        .mem_stall(mem_stall), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rsp_valid) rsp_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [31:0] eff_addr(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return a;
        if (sz == 2'd1) return a - (a % 2);
        return a - (a % 4);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_ben(input logic [1:0] sz, input logic [31:0] a);
        int n;
        int mask;
        n = nbytes(sz);
        mask = (1 << n) - 1;
        return 4'((mask << (eff_addr(sz, a) % 4)) & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic st, input logic [1:0] sz, input logic [31:0] wd);
        if (!st) return 32'd0;
        if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [32:0] model_rsp(input logic st, input logic [1:0] sz, input logic sg,
                                              input logic [31:0] a, input logic [31:0] rd,
                                              input logic me, input logic bad);
        longint unsigned v;
        longint unsigned span;
        int n;
        if (bad || me) return {1'b1, 32'd0};
        if (st) return 33'd0;
        n = nbytes(sz);
        span = 64'd1 << (8 * n);
        v = longint'(rd) >> (8 * (eff_addr(sz, a) % 4));
        v = v % span;
        if (sg && n < 4 && v >= span / 2) v = v - span;
        return {1'b0, v[31:0]};
    endfunction

    // driver: one full transaction, checked cycle by cycle
    task automatic run_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic me, input int stalls);
        logic bad;
        logic [32:0] e;
        bad = (sz == 2'd3) ||
              (TRAP && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)));
        exp_q.push_back(model_rsp(st, sz, sg, a, rd, me, bad));
        rsp_expected++;
        @(negedge clk);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_ready", req_ready, 1);
        check("idle_c_en", mem_c_en, 0);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_store = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_signed = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
        if (!bad) begin
            for (int k = 0; k <= stalls; k++) begin
                mem_stall = (k < stalls);
                check("acc_c_en", mem_c_en, 1);
                check("acc_addr", mem_addr, eff_addr(2'd2, a));
                check("acc_b_en", mem_b_en, model_ben(sz, a));
                check("acc_wdata", mem_wdata, model_wdata(st, sz, wd));
                check("acc_rsp_valid", rsp_valid, 0);
                check("acc_ready", req_ready, 0);
                @(negedge clk);
            end
            mem_stall = $urandom_range(0, 1);
            mem_rdata = rd; mem_error = me;
            check("cap_c_en", mem_c_en, 0);
            check("cap_b_en", mem_b_en, 0);
            check("cap_addr", mem_addr, 0);
            check("cap_wdata", mem_wdata, 0);
            check("cap_rsp_valid", rsp_valid, 0);
            @(negedge clk);
            mem_stall = 1'b0; mem_rdata = $urandom; mem_error = $urandom_range(0, 1);
        end else begin
            check("trap_c_en", mem_c_en, 0);
        end
        check("rsp_valid", rsp_valid, 1);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("rsp_error", rsp_error, 32'(e[32]));
            check("rsp_rdata", rsp_rdata, e[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_store = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        mem_rdata = 0; mem_error = 0; mem_stall = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_state", fsm_state, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_c_en", mem_c_en, 0);
        check("rst_b_en", mem_b_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;

        // directed cases
        run_op(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);   // LW
        run_op(0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0, 0);   // LB
        run_op(0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 0, 0);   // LBU
        run_op(0, 2'd1, 0, 32'h102, 32'h0, 32'h80112233, 0, 0);   // LHU
        run_op(1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'hFFFF0000, 0, 3); // SH stalled
        run_op(0, 2'd2, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0);   // misaligned LW
        run_op(0, 2'd1, 1, 32'h305, 32'h0, 32'h8001F00D, 0, 1);   // misaligned LH
        run_op(0, 2'd2, 0, 32'h400, 32'h0, 32'h12345678, 1, 0);   // memory error
        run_op(1, 2'd0, 0, 32'h401, 32'h000000A5, 32'h0, 0, 0);   // back-to-back SB
        run_op(0, 2'd3, 0, 32'h500, 32'h0, 32'h11111111, 0, 0);   // illegal size
        run_op(1, 2'd2, 0, 32'h504, 32'h87654321, 32'h0, 0, 2);   // SW

        // reset during a stalled access
        @(negedge clk);
        req_valid = 1; req_store = 0; req_size = 2'd2; req_addr = 32'h300; mem_stall = 1;
        @(negedge clk);
        req_valid = 0;
        check("pre_rst_c_en", mem_c_en, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_rst_c_en", mem_c_en, 0);
        @(negedge clk);
        check("in_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0; mem_stall = 0;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_state", fsm_state, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 0);
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($urandom_range(0, 1), sz, $urandom_range(0, 1), $urandom, $urandom,
                   $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        @(negedge clk);
        check("rsp_count", rsp_seen, rsp_expected);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
